// File: rtl/m_dram_arbiter.sv
// m_dram_arbiter: buffers one DRAM request per hart and serialises them round-robin onto a
// single controller port. Define DRAM_ARB_STATS_EN to add per-hart grant/wait counters.
module m_dram_arbiter #(
  parameter int NHARTS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 w_init_done,
  input  logic [32*NHARTS-1:0] w_req_addr,
  input  logic [32*NHARTS-1:0] w_req_wdata,
  input  logic [NHARTS-1:0]    w_req_we,
  input  logic [3*NHARTS-1:0]  w_req_ctrl,
  input  logic [NHARTS-1:0]    w_req_le,
  output logic [32*NHARTS-1:0] r_req_odata,
  output logic [NHARTS-1:0]    w_req_busy,
  output logic [31:0]          r_dram_addr,
  output logic [31:0]          r_dram_wdata,
  output logic                 r_dram_we,
  output logic [2:0]           r_dram_ctrl,
  output logic                 r_dram_le,
  input  logic [31:0]          w_dram_odata,
  input  logic                 w_dram_busy
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [32*NHARTS-1:0] r_grant_cnt,
  output logic [32*NHARTS-1:0] r_wait_cnt
`endif
);
  localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e            state_q;
  logic [NHARTS-1:0] pend_q;
  logic [31:0]       addr_q  [NHARTS];
  logic [31:0]       wdata_q [NHARTS];
  logic [2:0]        ctrl_q  [NHARTS];
  logic [31:0]       odata_q [NHARTS];
  logic [NHARTS-1:0] we_q;
  logic [IW-1:0]     gnt_q;
  logic [IW-1:0]     last_q;
  logic [31:0]       dram_addr_q;
  logic [31:0]       dram_wdata_q;
  logic              dram_we_q;
  logic [2:0]        dram_ctrl_q;
  logic              dram_le_q;

  logic [IW-1:0]     sel_d;
  logic              sel_vld_d;
  logic              grant_d;
  int unsigned       idx;

  // Round-robin search starting one past the last winner, wrapping at NHARTS.
  always_comb begin
    sel_d     = last_q;
    sel_vld_d = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NHARTS; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= unsigned'(NHARTS)) idx = idx - unsigned'(NHARTS);
      if (!sel_vld_d && pend_q[IW'(idx)]) begin
        sel_vld_d = 1'b1;
        sel_d     = IW'(idx);
      end
    end
    grant_d = (state_q == S_IDLE) && w_init_done && sel_vld_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      we_q         <= '0;
      gnt_q        <= '0;
      last_q       <= IW'(NHARTS - 1);
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      dram_we_q    <= 1'b0;
      dram_ctrl_q  <= '0;
      dram_le_q    <= 1'b0;
      for (int unsigned i = 0; i < NHARTS; i++) begin
        addr_q[IW'(i)]  <= '0;
        wdata_q[IW'(i)] <= '0;
        ctrl_q[IW'(i)]  <= '0;
        odata_q[IW'(i)] <= '0;
      end
    end else begin
      // A launch while already pending is a protocol error and is dropped.
      for (int unsigned i = 0; i < NHARTS; i++) begin
        if (w_req_le[IW'(i)] && !pend_q[IW'(i)]) begin
          addr_q[IW'(i)]  <= w_req_addr[32*i +: 32];
          wdata_q[IW'(i)] <= w_req_wdata[32*i +: 32];
          ctrl_q[IW'(i)]  <= w_req_ctrl[3*i +: 3];
          we_q[IW'(i)]    <= w_req_we[IW'(i)];
          pend_q[IW'(i)]  <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            dram_addr_q  <= addr_q[sel_d];
            dram_wdata_q <= wdata_q[sel_d];
            dram_we_q    <= we_q[sel_d];
            dram_ctrl_q  <= ctrl_q[sel_d];
            dram_le_q    <= 1'b1;
            gnt_q        <= sel_d;
            last_q       <= sel_d;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dram_le_q <= 1'b0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (!w_dram_busy) begin
            if (!dram_we_q) odata_q[gnt_q] <= w_dram_odata;
            pend_q[gnt_q] <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    r_req_odata = '0;
    for (int unsigned i = 0; i < NHARTS; i++) r_req_odata[32*i +: 32] = odata_q[IW'(i)];
  end

  assign w_req_busy   = pend_q;
  assign r_dram_addr  = dram_addr_q;
  assign r_dram_wdata = dram_wdata_q;
  assign r_dram_we    = dram_we_q;
  assign r_dram_ctrl  = dram_ctrl_q;
  assign r_dram_le    = dram_le_q;

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] gcnt_q [NHARTS];
  logic [31:0] wcnt_q [NHARTS];

  // A hart counts as granted while it owns the port or is being granted this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NHARTS; i++) begin
        gcnt_q[IW'(i)] <= '0;
        wcnt_q[IW'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NHARTS; i++) begin
        if (grant_d && sel_d == IW'(i)) gcnt_q[IW'(i)] <= gcnt_q[IW'(i)] + 32'd1;
        if (pend_q[IW'(i)] && !((grant_d && sel_d == IW'(i)) ||
                                (state_q != S_IDLE && gnt_q == IW'(i))))
          wcnt_q[IW'(i)] <= wcnt_q[IW'(i)] + 32'd1;
      end
    end
  end

  always_comb begin
    r_grant_cnt = '0;
    r_wait_cnt  = '0;
    for (int unsigned i = 0; i < NHARTS; i++) begin
      r_grant_cnt[32*i +: 32] = gcnt_q[IW'(i)];
      r_wait_cnt[32*i +: 32]  = wcnt_q[IW'(i)];
    end
  end
`endif

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Bench for m_dram_arbiter: transaction-level model of pending requests, round-robin order
// and launch/complete timing, plus a simple DRAM controller responder.
module tb_m_dram_arbiter;
  localparam int NH = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            w_init_done = 1'b0;
  logic [32*NH-1:0] w_req_addr = '0;
  logic [32*NH-1:0] w_req_wdata = '0;
  logic [NH-1:0]   w_req_we = '0;
  logic [3*NH-1:0] w_req_ctrl = '0;
  logic [NH-1:0]   w_req_le = '0;
  logic [32*NH-1:0] r_req_odata;
  logic [NH-1:0]   w_req_busy;
  logic [31:0]     r_dram_addr;
  logic [31:0]     r_dram_wdata;
  logic            r_dram_we;
  logic [2:0]      r_dram_ctrl;
  logic            r_dram_le;
  logic [31:0]     w_dram_odata = '0;
  logic            w_dram_busy = 1'b0;

  always #5 CLK = ~CLK;

  m_dram_arbiter #(.NHARTS(NH)) dut (
    .CLK(CLK), .RST(RST), .w_init_done(w_init_done),
    .w_req_addr(w_req_addr), .w_req_wdata(w_req_wdata), .w_req_we(w_req_we),
    .w_req_ctrl(w_req_ctrl), .w_req_le(w_req_le),
    .r_req_odata(r_req_odata), .w_req_busy(w_req_busy),
    .r_dram_addr(r_dram_addr), .r_dram_wdata(r_dram_wdata), .r_dram_we(r_dram_we),
    .r_dram_ctrl(r_dram_ctrl), .r_dram_le(r_dram_le),
    .w_dram_odata(w_dram_odata), .w_dram_busy(w_dram_busy)
  );

  int cyc = -1;
  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // staged stimulus for the current cycle
  logic          s_rst = 1'b1;
  logic          s_init = 1'b0;
  logic [NH-1:0] s_le = '0;
  logic [NH-1:0] s_we = '0;
  logic [31:0]   s_addr [NH];
  logic [31:0]   s_wdata [NH];
  logic [2:0]    s_ctrl [NH];

  // controller responder
  int          ctl_cnt = 0;
  int          ctl_k = 3;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_val = '0;

  // reference model
  logic [NH-1:0] m_pend = '0;
  logic [NH-1:0] m_we = '0;
  logic [31:0]   m_addr [NH];
  logic [31:0]   m_wdata [NH];
  logic [2:0]    m_ctrl [NH];
  logic [31:0]   m_odata [NH];
  int            m_last = NH - 1;
  int            m_cur = -1;
  int            m_launch = 0;
  bit            m_post_rst = 1'b0;

  // launch log
  int          pulse_cnt = 0;
  int          first_pulse = -1;
  logic [31:0] pulse_q [$];

  bit auto_en = 1'b0;
  int auto_cnt [NH];

  function automatic logic [31:0] dram_resp(input logic [31:0] a);
    if (fixed_en) return fixed_val;
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
  endtask

  task automatic check_outputs();
    chk("busy", 32'(w_req_busy), 32'(m_pend));
    for (int i = 0; i < NH; i++)
      chk($sformatf("odata%0d", i), r_req_odata[32*i +: 32], m_odata[i]);
    chk("dram_le", 32'(r_dram_le), 32'(m_cur >= 0 && cyc == m_launch));
    if (m_cur >= 0 && cyc >= m_launch) begin
      chk("dram_addr", r_dram_addr, m_addr[m_cur]);
      chk("dram_wdata", r_dram_wdata, m_wdata[m_cur]);
      chk("dram_we", 32'(r_dram_we), 32'(m_we[m_cur]));
      chk("dram_ctrl", 32'(r_dram_ctrl), 32'(m_ctrl[m_cur]));
    end
    if (m_post_rst) begin
      chk("rst_dram_addr", r_dram_addr, 32'h0);
      chk("rst_dram_wdata", r_dram_wdata, 32'h0);
      chk("rst_dram_we_ctrl", {28'h0, r_dram_we, r_dram_ctrl}, 32'h0);
      m_post_rst = 1'b0;
    end
  endtask

  task automatic model_update();
    logic [NH-1:0] p0;
    int sel;
    if (s_rst) begin
      m_pend = '0;
      for (int i = 0; i < NH; i++) m_odata[i] = '0;
      m_last = NH - 1;
      m_cur = -1;
      m_post_rst = 1'b1;
      chk_en = 1'b1;
      return;
    end
    p0 = m_pend;
    if (m_cur >= 0 && cyc > m_launch && !w_dram_busy) begin
      if (!m_we[m_cur]) m_odata[m_cur] = dram_resp(m_addr[m_cur]);
      m_pend[m_cur] = 1'b0;
      m_cur = -1;
    end else if (m_cur < 0 && s_init && p0 != '0) begin
      for (int k = 1; k <= NH; k++) begin
        sel = (m_last + k) % NH;
        if (p0[sel]) begin
          m_cur = sel;
          m_launch = cyc + 1;
          m_last = sel;
          break;
        end
      end
    end
    for (int i = 0; i < NH; i++) begin
      if (s_le[i] && !p0[i]) begin
        m_addr[i] = s_addr[i];
        m_wdata[i] = s_wdata[i];
        m_we[i] = s_we[i];
        m_ctrl[i] = s_ctrl[i];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic do_cycle();
    @(negedge CLK);
    cyc++;
    if (chk_en) check_outputs();
    if (r_dram_le === 1'b1) begin
      pulse_cnt++;
      if (first_pulse < 0) first_pulse = cyc;
      pulse_q.push_back(r_dram_addr);
    end
    if (s_rst) begin
      ctl_cnt = 0;
      w_dram_busy = 1'b0;
    end else begin
      w_dram_busy = (ctl_cnt > 0);
      if (ctl_cnt > 0) ctl_cnt--;
      if (r_dram_le === 1'b1) ctl_cnt = ctl_k;
    end
    w_dram_odata = dram_resp(r_dram_addr);
    if (auto_en) begin
      for (int i = 0; i < NH; i++) begin
        if (auto_cnt[i] < 20 && w_req_busy[i] === 1'b0) begin
          s_le[i] = 1'b1; s_we[i] = 1'b0;
          s_addr[i] = {4'(i), 28'(auto_cnt[i])};
          s_wdata[i] = '0; s_ctrl[i] = 3'd2;
          auto_cnt[i]++;
        end
      end
    end
    RST = s_rst;
    w_init_done = s_init;
    w_req_le = s_le;
    w_req_we = s_we;
    for (int i = 0; i < NH; i++) begin
      w_req_addr[32*i +: 32] = s_addr[i];
      w_req_wdata[32*i +: 32] = s_wdata[i];
      w_req_ctrl[3*i +: 3] = s_ctrl[i];
    end
    model_update();
    s_le = '0;
  endtask

  task automatic clr_log();
    pulse_cnt = 0;
    first_pulse = -1;
    pulse_q.delete();
  endtask

  task automatic reset_dut();
    s_rst = 1'b1;
    do_cycle();
    do_cycle();
    s_rst = 1'b0;
  endtask

  task automatic stage(input int h, input logic we, input logic [31:0] a, input logic [31:0] d);
    s_le[h] = 1'b1; s_we[h] = we; s_addr[h] = a; s_wdata[h] = d; s_ctrl[h] = 3'd2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int c0, last_busy, viol;
    bit done;
    for (int i = 0; i < NH; i++) begin
      s_addr[i] = '0; s_wdata[i] = '0; s_ctrl[i] = '0;
      m_addr[i] = '0; m_wdata[i] = '0; m_ctrl[i] = '0; m_odata[i] = '0;
      auto_cnt[i] = 0;
    end
    reset_dut();
    do_cycle();
    chk("reset_busy", 32'(w_req_busy), 32'h0);
    chk("reset_odata", r_req_odata[31:0] | r_req_odata[63:32], 32'h0);

    // 1: single load, controller busy for 5 cycles
    s_init = 1'b1; ctl_k = 5; fixed_en = 1'b1; fixed_val = 32'hDEAD_BEEF;
    clr_log();
    stage(0, 1'b0, 32'h8000_0010, 32'h0);
    do_cycle();
    c0 = cyc; last_busy = -1;
    repeat (12) begin
      do_cycle();
      if (w_req_busy[0]) last_busy = cyc - c0;
    end
    chk("t1_launch_offset", 32'(first_pulse - c0), 32'd2);
    chk("t1_pulses", 32'(pulse_cnt), 32'd1);
    chk("t1_busy_last", 32'(last_busy), 32'd8);
    chk("t1_odata0", r_req_odata[31:0], 32'hDEAD_BEEF);
    fixed_en = 1'b0;

    // 2: simultaneous store on hart0 and load on hart1 from reset
    reset_dut();
    clr_log(); ctl_k = 3;
    stage(0, 1'b1, 32'h0000_0100, 32'h11);
    stage(1, 1'b0, 32'h0000_0200, 32'h0);
    repeat (25) do_cycle();
    chk("t2_pulses", 32'(pulse_cnt), 32'd2);
    if (pulse_q.size() == 2) begin
      chk("t2_first", pulse_q[0], 32'h0000_0100);
      chk("t2_second", pulse_q[1], 32'h0000_0200);
    end
    chk("t2_odata0", r_req_odata[31:0], 32'h0);
    chk("t2_odata1", r_req_odata[63:32], 32'hA7A5_0F0F);

    // 4: relaunch on hart1 while busy is ignored
    clr_log(); ctl_k = 5;
    stage(1, 1'b0, 32'h0000_0300, 32'h0);
    do_cycle();
    repeat (4) begin
      stage(1, 1'b0, 32'hFFFF_FFFF, 32'h0);
      do_cycle();
    end
    repeat (20) do_cycle();
    chk("t4_pulses", 32'(pulse_cnt), 32'd1);
    if (pulse_q.size() >= 1) chk("t4_addr", pulse_q[0], 32'h0000_0300);
    chk("t4_odata1", r_req_odata[63:32], 32'hA6A5_0F0F);

    // 5: no grant while init_done is low
    clr_log(); ctl_k = 2; s_init = 1'b0;
    stage(0, 1'b0, 32'h0000_0500, 32'h0);
    stage(1, 1'b1, 32'h0000_0600, 32'h77);
    repeat (9) do_cycle();
    chk("t5_no_pulse", 32'(pulse_cnt), 32'd0);
    s_init = 1'b1;
    do_cycle();
    c0 = cyc;
    repeat (25) do_cycle();
    chk("t5_first_offset", 32'(first_pulse - c0), 32'd1);
    chk("t5_pulses", 32'(pulse_cnt), 32'd2);

    // 3: fairness with immediate relaunch
    reset_dut();
    clr_log(); auto_en = 1'b1; done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      ctl_k = $urandom_range(1, 4);
      do_cycle();
      if (auto_cnt[0] == 20 && auto_cnt[1] == 20 && pulse_cnt == 40 && w_req_busy == '0) done = 1'b1;
    end
    auto_en = 1'b0;
    chk("t3_completed", 32'(done), 32'd1);
    chk("t3_pulses", 32'(pulse_cnt), 32'd40);
    viol = 0;
    for (int k = 1; k < pulse_q.size(); k++)
      if (pulse_q[k][31:28] == pulse_q[k-1][31:28]) viol++;
    chk("t3_alternation", 32'(viol), 32'd0);
    if (pulse_q.size() > 0) chk("t3_first_hart", 32'(pulse_q[0][31:28]), 32'd0);

    // 6: reset while waiting on the controller
    clr_log(); ctl_k = 8;
    stage(0, 1'b0, 32'h0000_0400, 32'h0);
    repeat (5) do_cycle();
    s_rst = 1'b1;
    do_cycle();
    s_rst = 1'b0;
    do_cycle();
    chk("t6_busy", 32'(w_req_busy), 32'h0);
    chk("t6_dram_addr", r_dram_addr, 32'h0);
    clr_log();
    repeat (10) do_cycle();
    chk("t6_no_pulse", 32'(pulse_cnt), 32'd0);

    // randomized traffic, including protocol errors, init drops and resets
    for (int n = 0; n < 3000; n++) begin
      s_init = ($urandom_range(0, 15) != 0);
      s_rst = ($urandom_range(0, 399) == 0);
      ctl_k = $urandom_range(1, 6);
      for (int i = 0; i < NH; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          s_le[i] = 1'b1;
          s_we[i] = 1'($urandom_range(0, 1));
          s_addr[i] = $urandom;
          s_wdata[i] = $urandom;
          s_ctrl[i] = 3'($urandom_range(0, 7));
        end
      end
      do_cycle();
    end
    s_rst = 1'b0;
    repeat (20) do_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
